camera_stream_gen: RTL
======================

Name: camera_stream_gen

Overview:
- Transmit-side counterpart of camera_read: emulates the OV7670 parallel output (vsync/href/p_data) from a 16-bit RGB565 frame buffer.
- Lets camera_read and the digit-recognition pipeline run in loopback without a physical sensor.
- Reads pixels from a synchronous frame-buffer RAM in linear address order.
- Serialises each pixel as two bytes, high byte first, with frame/line blanking set by parameters.

Parameters:
H_ACTIVE, 320, pixels per line (href high for 2*H_ACTIVE cycles)
V_ACTIVE, 240, lines per frame; H_ACTIVE*V_ACTIVE <= 2^17
H_BLANK, 144, href-low cycles after every line; must be >= 2
VSYNC_LEN, 3, vsync-high cycles per frame; must be >= 1
V_BACK, 17, idle cycles between vsync fall and first href; must be >= 2
V_FRONT, 10, idle cycles after the last line's H_BLANK; must be >= 1

Ports:
p_clock  in  1  pixel clock, all logic on rising edge
reset  in  1  asynchronous, active-high
start  in  1  sampled in IDLE; begins a frame
continuous  in  1  sampled at end of V_FRONT; 1 = start the next frame immediately
mem_rd_en  out  1  one-cycle read strobe to frame buffer
mem_addr  out  17  pixel index being read
mem_rd_data  in  16  RGB565 word, valid the cycle after mem_rd_en
vsync  out  1  frame sync, registered
href  out  1  line valid, registered
p_data  out  8  pixel byte, registered
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse in the last V_FRONT cycle

Behaviour:
- Reset (async, immediate): state=IDLE; vsync, href, mem_rd_en, busy and frame_done = 0; p_data=8'h00; mem_addr=0; all counters 0. Applies mid-frame; no partial line is completed.
- States and transitions:
  - IDLE: start=1 -> VSYNC on the next edge.
  - VSYNC: vsync=1 for exactly VSYNC_LEN cycles; pixel index cleared to 0 -> VBACK.
  - VBACK: V_BACK cycles, all outputs idle -> ACTIVE.
  - ACTIVE: 2*H_ACTIVE cycles, href=1 -> HBLANK.
  - HBLANK: H_BLANK cycles, href=0. Not last line -> ACTIVE. Last line -> VFRONT.
  - VFRONT: V_FRONT cycles; frame_done=1 in the final cycle. Then continuous=1 -> VSYNC, else -> IDLE.
- Byte order: in ACTIVE, even cycles carry pixel[15:8] and odd cycles carry pixel[7:0]. This matches camera_read assembly, so byte0 ends up in pixel_data[15:8].
- p_data = 8'h00 whenever href=0.
- Fetch timing:
  - Pixel k is read with mem_rd_en=1 and mem_addr=k in cycle c.
  - Its high byte appears on p_data/href in cycle c+2; its low byte in cycle c+3.
  - Fetches are therefore issued two cycles ahead of each pixel's high-byte cycle. The first fetch of each line falls in the second-to-last cycle of VBACK/HBLANK, which is why both must be >= 2.
  - Exactly one fetch per pixel; mem_rd_en=0 otherwise.
- Address rules: mem_addr increments 0..H_ACTIVE*V_ACTIVE-1 across the frame with no wrap mid-frame. It holds its last value between fetches and returns to 0 in VSYNC.
- start while busy=1 is ignored.
- start and continuous are only sampled at the points stated above.
- Frame length from vsync rise to frame_done: VSYNC_LEN+V_BACK+V_ACTIVE*(2*H_ACTIVE+H_BLANK)+V_FRONT-1 cycles.
- Counters are sized to the largest parameter; no arithmetic overflow for legal parameters.

Test Plan:
Common setup: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=3, VSYNC_LEN=2, V_BACK=3, V_FRONT=2. RAM model returns {addr[7:0], ~addr[7:0]}.
1. Reset, then a start pulse -> vsync high exactly 2 cycles, then 3 idle cycles. href is high 8 cycles per line, 3 lines, each followed by 3 href-low cycles. frame_done pulses 39 cycles after the vsync rising cycle; busy then drops and state is IDLE.
2. Line 0 p_data sequence -> 00,FF,01,FE,02,FD,03,FC. Line 2 -> 08,F7,09,F6,0A,F5,0B,F4. mem_rd_en fires 12 times with mem_addr 0..11, each exactly 2 cycles before the matching high byte.
3. continuous=1 -> the next vsync rises the cycle after frame_done. The frame repeats with mem_addr restarting at 0 and identical bytes.
4. start re-pulsed during ACTIVE -> no effect on timing; only one frame is sent when continuous=0.
5. reset asserted mid-line (href=1) -> all outputs 0 immediately without waiting for a clock. After release, a new start produces a clean frame from address 0.
6. Loopback into camera_read (default parameters, constant RAM 16'hFF11) -> pixel_data=16'hFF11, 76800 pixel_valid pulses, addresses 0..76799, one frame_done per frame.

Source files
------------

// File: rtl/camera_stream_gen_if.sv
// -----------------------------------------------------------------------------
// camera_stream_gen_if
//   Bundles the frame-buffer read bus and the OV7670-style parallel video
//   output of camera_stream_gen.
//
//   mem_rd_en   : one-cycle read strobe towards the frame buffer
//   mem_addr    : linear pixel index being read (17 bits)
//   mem_rd_data : RGB565 word returned the cycle after mem_rd_en
//   vsync       : frame sync
//   href        : line valid
//   p_data      : pixel byte, high byte of each pixel first
//
//   master : the stream generator (drives strobe/address/video)
//   slave  : the RAM plus video sink (returns read data, observes video)
// -----------------------------------------------------------------------------
interface camera_stream_gen_if;
   logic        mem_rd_en;
   logic [16:0] mem_addr;
   logic [15:0] mem_rd_data;
   logic        vsync;
   logic        href;
   logic [7:0]  p_data;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rd_data,
      output vsync,
      output href,
      output p_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rd_data,
      input  vsync,
      input  href,
      input  p_data
   );
endinterface

// File: rtl/camera_stream_gen.sv
// -----------------------------------------------------------------------------
// camera_stream_gen
//   Emulates the OV7670 parallel output (vsync / href / p_data) by streaming
//   a 16-bit RGB565 frame buffer.  Pixels are fetched from a synchronous RAM
//   in linear order and serialised as two bytes, high byte first, with
//   frame and line blanking set by parameters.
//
//   Ports:
//     p_clock    : pixel clock, all logic on the rising edge
//     reset      : asynchronous, active-high
//     start      : sampled only in IDLE; begins a frame
//     continuous : sampled in the last V_FRONT cycle; 1 = chain next frame
//     busy       : high in every state except IDLE
//     frame_done : one-cycle pulse in the last V_FRONT cycle
//     bus        : frame-buffer read bus and video outputs (master side)
//
//   Legal parameters: H_BLANK >= 2, V_BACK >= 2, VSYNC_LEN >= 1,
//   V_FRONT >= 1, H_ACTIVE*V_ACTIVE <= 2**17.
// -----------------------------------------------------------------------------
module camera_stream_gen #(
   parameter int H_ACTIVE  = 320,
   parameter int V_ACTIVE  = 240,
   parameter int H_BLANK   = 144,
   parameter int VSYNC_LEN = 3,
   parameter int V_BACK    = 17,
   parameter int V_FRONT   = 10
) (
   input  logic                       p_clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       continuous,
   output logic                       busy,
   output logic                       frame_done,
   camera_stream_gen_if.master        bus
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int LINE_LEN = 2 * H_ACTIVE;
   localparam int CNT_MAX  = max2(max2(LINE_LEN, H_BLANK),
                                  max2(max2(VSYNC_LEN, V_BACK), V_FRONT));
   localparam int CW       = $clog2(CNT_MAX + 1);
   localparam int LW       = max2($clog2(V_ACTIVE + 1), 1);

   localparam logic [CW-1:0] VSYNC_LAST  = CW'(VSYNC_LEN - 1);
   localparam logic [CW-1:0] VBACK_LAST  = CW'(V_BACK - 1);
   localparam logic [CW-1:0] ACTIVE_LAST = CW'(LINE_LEN - 1);
   localparam logic [CW-1:0] HBLANK_LAST = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VFRONT_LAST = CW'(V_FRONT - 1);
   // Fetches lead each high byte by two cycles, so the first fetch of a
   // line sits in the second-to-last blanking cycle.
   localparam logic [CW-1:0] VBACK_FETCH  = CW'(V_BACK - 2);
   localparam logic [CW-1:0] HBLANK_FETCH = CW'(H_BLANK - 2);
   // Inside a line, fetches for the remaining pixels happen on even byte
   // slots strictly below LINE_LEN-2.
   localparam logic [CW-1:0] ACTIVE_FETCH_LIMIT = CW'(LINE_LEN - 2);
   localparam logic [LW-1:0] LINE_LAST   = LW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_HBLANK,
      ST_VFRONT
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg,   cnt_next;
   logic [LW-1:0]   line_reg,  line_next;
   // One bit wider than the address so the post-frame increment cannot wrap.
   logic [17:0]     idx_reg;
   logic [16:0]     addr_reg;
   logic            rd_en_reg;
   logic            vsync_reg, href_reg, busy_reg, frame_done_reg;
   logic [7:0]      p_data_reg;
   logic [7:0]      lo_byte_reg;

   logic            vsync_next, href_next, busy_next, done_next, fetch_next;

   // -------------------------------------------------------------------------
   // Next-state logic: cnt counts cycles inside the current state.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      line_next  = line_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_VSYNC;
               cnt_next   = '0;
            end
         end
         ST_VSYNC: begin
            if (cnt_reg == VSYNC_LAST) begin
               state_next = ST_VBACK;
               cnt_next   = '0;
               line_next  = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_VBACK: begin
            if (cnt_reg == VBACK_LAST) begin
               state_next = ST_ACTIVE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_ACTIVE: begin
            if (cnt_reg == ACTIVE_LAST) begin
               state_next = ST_HBLANK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_HBLANK: begin
            if (cnt_reg == HBLANK_LAST) begin
               cnt_next = '0;
               if (line_reg == LINE_LAST) begin
                  state_next = ST_VFRONT;
               end else begin
                  state_next = ST_ACTIVE;
                  line_next  = line_reg + LW'(1);
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_VFRONT: begin
            if (cnt_reg == VFRONT_LAST) begin
               cnt_next   = '0;
               state_next = continuous ? ST_VSYNC : ST_IDLE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            line_next  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode.  Every output is registered from the *next* state, so the
   // registered outputs line up exactly with the state they describe.
   // -------------------------------------------------------------------------
   always_comb begin
      vsync_next = (state_next == ST_VSYNC);
      href_next  = (state_next == ST_ACTIVE);
      busy_next  = (state_next != ST_IDLE);
      done_next  = (state_next == ST_VFRONT) && (cnt_next == VFRONT_LAST);
      fetch_next = 1'b0;
      if ((state_next == ST_VBACK) && (cnt_next == VBACK_FETCH)) begin
         fetch_next = 1'b1;
      end
      if ((state_next == ST_HBLANK) && (cnt_next == HBLANK_FETCH) &&
          (line_next != LINE_LAST)) begin
         fetch_next = 1'b1;
      end
      if ((state_next == ST_ACTIVE) && !cnt_next[0] &&
          (cnt_next < ACTIVE_FETCH_LIMIT)) begin
         fetch_next = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge p_clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         line_reg       <= '0;
         idx_reg        <= '0;
         addr_reg       <= '0;
         rd_en_reg      <= 1'b0;
         vsync_reg      <= 1'b0;
         href_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         p_data_reg     <= 8'h00;
         lo_byte_reg    <= 8'h00;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         line_reg       <= line_next;
         vsync_reg      <= vsync_next;
         href_reg       <= href_next;
         busy_reg       <= busy_next;
         frame_done_reg <= done_next;
         rd_en_reg      <= fetch_next;

         if (state_next == ST_VSYNC) begin
            idx_reg  <= '0;
            addr_reg <= '0;
         end else if (fetch_next) begin
            addr_reg <= idx_reg[16:0];
            idx_reg  <= idx_reg + 18'd1;
         end

         // RAM data is valid the cycle before its high-byte slot; the low
         // byte is parked so it can follow one cycle later.
         if (href_next) begin
            if (!cnt_next[0]) begin
               p_data_reg  <= bus.mem_rd_data[15:8];
               lo_byte_reg <= bus.mem_rd_data[7:0];
            end else begin
               p_data_reg  <= lo_byte_reg;
            end
         end else begin
            p_data_reg <= 8'h00;
         end
      end
   end

   assign bus.mem_rd_en = rd_en_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.vsync     = vsync_reg;
   assign bus.href      = href_reg;
   assign bus.p_data    = p_data_reg;
   assign busy          = busy_reg;
   assign frame_done    = frame_done_reg;

endmodule
